ghost_mover: RTL and testbench
==============================

Name: ghost_mover

Overview:
Parametrised successor to the fixed-table ghost controller. It owns one ghost's position and heading, steps it on a programmable tick, and picks new headings when blocked. Heading selection uses an LFSR and supports four modes: random, chase-target, frightened and hold. It sits between the maze collision checker, which reports whether the current heading is clear, and the VGA sprite renderer, which consumes x, y and direction.

Parameters:
X_W, 10, width of x coordinate
Y_W, 9, width of y coordinate
START_X, 45, reset x
START_Y, 45, reset y
START_DIR, 2'b01, reset heading
STEP_PERIOD, 131072, clk cycles per movement tick (>=2)
CHECK_LAT, 2, cycles allowed for collision checker to settle after a heading change (>=1)
MAX_RETRY, 4, failed turn attempts before forced reversal
X_MAX, 639, highest legal x; x wraps between 0 and X_MAX (tunnel)
LFSR_SEED, 16'hACE1, nonzero LFSR reset value

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
enable  in  1  1 = ghost runs; 0 = freeze (tick counter and FSM hold)
mode  in  2  00 RANDOM, 01 CHASE, 10 FRIGHTENED, 11 HOLD
target_x  in  X_W  chase target x
target_y  in  Y_W  chase target y
path_clear  in  1  from collision checker: 1 = step in current direction is free
x  out  X_W  ghost x
y  out  Y_W  ghost y
direction  out  2  heading: 00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1)
next_dir  out  2  candidate heading for next turn (combinational from LFSR/mode)
moving  out  1  1 in the cycle a step is taken
turning  out  1  1 while FSM is in TURN or CHECK

Behaviour:
- Reset (rst=0, async): x=START_X, y=START_Y, direction=START_DIR, FSM=MOVE, tick cnt=0, retry=0, lfsr=LFSR_SEED, moving=0, turning=0.
- Tick: cnt counts 0..STEP_PERIOD-1 while enable=1; tick is asserted in the cycle cnt==STEP_PERIOD-1, then cnt wraps to 0.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, advances every clk regardless of enable; never reaches 0.
- FSM MOVE: on tick and mode!=HOLD:
  - if path_clear, step one pixel in direction and pulse moving for 1 cycle;
  - else latch direction<=next_dir, clear check counter, go CHECK.
- FSM CHECK: wait CHECK_LAT cycles, then sample path_clear.
  - 1: retry<=0, go MOVE; next step occurs on the following tick.
  - 0, retry<MAX_RETRY-1: retry++, direction<=next_dir, restart CHECK.
  - 0, retry==MAX_RETRY-1: direction<=reverse(direction at CHECK entry), retry<=0, go MOVE (no further check; MOVE re-evaluates on next tick).
- next_dir by mode:
  - RANDOM: lfsr[1:0].
  - CHASE, retry==0: dx=target_x-x, dy=target_y-y (signed, width+1). If |dx|>=|dy| choose right if dx>0 else left; otherwise down if dy>0 else up. dx=dy=0 gives current direction.
  - CHASE, retry>0: lfsr[1:0].
  - FRIGHTENED: lfsr[1:0], excluding reverse(direction); if equal, use lfsr[1:0]^2'b01.
- Frightened entry: in the cycle mode changes from non-FRIGHTENED to FRIGHTENED, direction<=reverse(direction) immediately. This has priority over a simultaneous tick: no step that cycle, and the FSM keeps its state.
- HOLD: position frozen; FSM returns to MOVE at the next tick if it was in CHECK; direction unchanged.
- enable=0: all state holds except the LFSR; outputs stable.
- Wrap: x==X_MAX stepping right gives 0; x==0 stepping left gives X_MAX. y wraps modulo 2^Y_W (the maze walls keep y legal).
- Turn opportunity: a new heading is chosen only when the current heading is blocked.
- Reset mid-CHECK: returns fully to reset values; no partial turn survives.

Decomposition:
- Shared package ghost_pkg:
  - direction encoding constants DIR_UP/DOWN/LEFT/RIGHT;
  - mode constants MODE_RANDOM/CHASE/FRIGHT/HOLD;
  - function reverse_dir (flip bit 0);
  - FSM state enum.
- One sub-module ghost_lfsr (SEED parameter, 16-bit output, clk, rst).

Test Plan:
- Reset: STEP_PERIOD=4, hold rst=0, release -> x=45, y=45, direction=01. With path_clear=1, y=46 on the first tick (4th cycle), moving pulses 1 cycle, then y=47 four cycles later.
- Blocked turn: path_clear=0 at a tick -> turning=1, direction=next_dir captured that cycle. Drive path_clear=1 after CHECK_LAT=2 cycles -> FSM in MOVE; step in the new heading on the next tick.
- Forced reversal: MAX_RETRY=4, path_clear held 0, heading right -> 4 attempts each of CHECK_LAT cycles, then direction=10 (left) and retry=0.
- Chase: mode=CHASE, x=45, y=45, target=(100,50), blocked -> next_dir=11. Target (50,10) -> next_dir=00.
- Frightened entry plus wrap: direction=11, x=X_MAX=639; switch mode to FRIGHTENED in the tick cycle -> direction=10, x stays 639. Separately, heading right at x=639 with path_clear=1 -> x=0 at the next tick.
- HOLD/enable: mode=HOLD for 3 ticks -> x, y unchanged. With enable=0, cnt frozen; re-enable -> tick resumes from the held count.

Source files
------------

// File: rtl/ghost_pkg.sv
// Shared encodings and helpers for the ghost movement controller.
package ghost_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam logic [1:0] MODE_RANDOM = 2'b00;
    localparam logic [1:0] MODE_CHASE  = 2'b01;
    localparam logic [1:0] MODE_FRIGHT = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    // Galois feedback mask for x^16+x^14+x^13+x^11+1 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        ST_MOVE  = 1'b0,
        ST_CHECK = 1'b1
    } ghost_state_t;

    // Opposite heading: up<->down, left<->right differ only in bit 0
    function automatic logic [1:0] reverse_dir(input logic [1:0] d);
        return {d[1], ~d[0]};
    endfunction

endpackage

// File: rtl/ghost_lfsr.sv
// Free-running 16-bit Galois LFSR used as the heading randomiser.
module ghost_lfsr
    import ghost_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr
);

    // Advance every cycle; a nonzero seed keeps the sequence off the all-zero lockup
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr <= SEED;
        else      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end

endmodule

// File: rtl/ghost_mover.sv
// One ghost: position/heading registers, movement tick, blocked-turn FSM.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_MOVE  | stepping on each tick while the heading is clear
// ST_CHECK | new heading latched, waiting for the collision checker
module ghost_mover
    import ghost_pkg::*;
#(
    parameter int          X_W         = 10,
    parameter int          Y_W         = 9,
    parameter int          START_X     = 45,
    parameter int          START_Y     = 45,
    parameter logic [1:0]  START_DIR   = 2'b01,
    parameter int          STEP_PERIOD = 131072,
    parameter int          CHECK_LAT   = 2,
    parameter int          MAX_RETRY   = 4,
    parameter int          X_MAX       = 639,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic [1:0]     mode,
    input  logic [X_W-1:0] target_x,
    input  logic [Y_W-1:0] target_y,
    input  logic           path_clear,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [1:0]     direction,
    output logic [1:0]     next_dir,
    output logic           moving,
    output logic           turning
);

    localparam int CNT_W = $clog2(STEP_PERIOD);
    localparam int CHK_W = $clog2(CHECK_LAT + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 1);
    localparam int D_W   = ((X_W > Y_W) ? X_W : Y_W) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_PERIOD - 1);
    localparam logic [CHK_W-1:0] CHK_LAST = CHK_W'(CHECK_LAT - 1);
    localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRY - 1);
    localparam logic [X_W-1:0]   X_LAST   = X_W'(X_MAX);

    ghost_state_t     state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CHK_W-1:0] chk;
    logic [RTY_W-1:0] retry;
    logic [1:0]       dir_entry;
    logic [1:0]       mode_q;
    logic [15:0]      lfsr;
    logic             lfsr_unused;

    logic tick, fright_entry, chk_done, retry_last;
    logic step_go, turn_go, retry_go, reverse_go, settle_go;

    logic signed [X_W:0] dx;
    logic signed [Y_W:0] dy;
    logic [D_W-1:0]      adx, ady;
    logic [1:0]          chase_dir, fright_dir;

    ghost_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr)
    );

    // Only the two low bits steer the heading
    assign lfsr_unused = ^lfsr[15:2];

    assign tick         = (cnt == CNT_LAST);
    assign chk_done     = (chk == CHK_LAST);
    assign retry_last   = (retry == RTY_LAST);
    assign fright_entry = enable && (mode == MODE_FRIGHT) && (mode_q != MODE_FRIGHT);

    // Movement tick counter, frozen while disabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        cnt <= '0;
        else if (enable) cnt <= tick ? '0 : cnt + 1'b1;
    end

    // Candidate heading for the next turn, selected by mode
    always_comb begin
        dx  = $signed({1'b0, target_x}) - $signed({1'b0, x});
        dy  = $signed({1'b0, target_y}) - $signed({1'b0, y});
        adx = D_W'(unsigned'(dx[X_W] ? -dx : dx));
        ady = D_W'(unsigned'(dy[Y_W] ? -dy : dy));
        if (dx == '0 && dy == '0)  chase_dir = direction;
        else if (adx >= ady)       chase_dir = (!dx[X_W] && dx != '0) ? DIR_RIGHT : DIR_LEFT;
        else                       chase_dir = (!dy[Y_W] && dy != '0) ? DIR_DOWN : DIR_UP;
        fright_dir = lfsr[1:0];
        if (fright_dir == reverse_dir(direction)) fright_dir = lfsr[1:0] ^ 2'b01;
        next_dir = lfsr[1:0];
        case (mode)
            MODE_CHASE:  next_dir = (retry == '0) ? chase_dir : lfsr[1:0];
            MODE_FRIGHT: next_dir = fright_dir;
            default:     next_dir = lfsr[1:0];
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        state <= ST_MOVE;
        else if (enable) state <= state_nx;
    end

    // Next-state and datapath strobes; frightened entry pre-empts everything
    always_comb begin
        state_nx   = state;
        step_go    = 1'b0;
        turn_go    = 1'b0;
        retry_go   = 1'b0;
        reverse_go = 1'b0;
        settle_go  = 1'b0;
        if (enable && !fright_entry) begin
            case (state)
                ST_MOVE: begin
                    if (tick && mode != MODE_HOLD) begin
                        if (path_clear) begin
                            step_go = 1'b1;
                        end else begin
                            turn_go  = 1'b1;
                            state_nx = ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (mode == MODE_HOLD) begin
                        if (tick) begin
                            settle_go = 1'b1;
                            state_nx  = ST_MOVE;
                        end
                    end else if (chk_done) begin
                        if (path_clear) begin
                            settle_go = 1'b1;
                            state_nx  = ST_MOVE;
                        end else if (retry_last) begin
                            reverse_go = 1'b1;
                            state_nx   = ST_MOVE;
                        end else begin
                            retry_go = 1'b1;
                        end
                    end
                end
                default: state_nx = ST_MOVE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        turning = (state == ST_CHECK);
    end

    // Position, heading, retry and settle counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x         <= X_W'(START_X);
            y         <= Y_W'(START_Y);
            direction <= START_DIR;
            dir_entry <= START_DIR;
            retry     <= '0;
            chk       <= '0;
            mode_q    <= MODE_RANDOM;
            moving    <= 1'b0;
        end else begin
            moving <= step_go;
            if (enable) begin
                mode_q <= mode;
                if (fright_entry) begin
                    direction <= reverse_dir(direction);
                end else if (step_go) begin
                    case (direction)
                        DIR_UP:   y <= y - 1'b1;
                        DIR_DOWN: y <= y + 1'b1;
                        DIR_LEFT: x <= (x == '0) ? X_LAST : x - 1'b1;
                        default:  x <= (x == X_LAST) ? '0 : x + 1'b1;
                    endcase
                end else if (turn_go) begin
                    dir_entry <= direction;
                    direction <= next_dir;
                    chk       <= '0;
                end else if (retry_go) begin
                    direction <= next_dir;
                    retry     <= retry + 1'b1;
                    chk       <= '0;
                end else if (reverse_go) begin
                    direction <= reverse_dir(dir_entry);
                    retry     <= '0;
                end else if (settle_go) begin
                    retry <= '0;
                end else if (state == ST_CHECK && mode != MODE_HOLD && !chk_done) begin
                    chk <= chk + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ghost_mover.sv
// Directed bench for ghost_mover with a short movement period.
module tb_ghost_mover;
    import ghost_pkg::*;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [1:0] mode;
    logic [9:0] target_x;
    logic [8:0] target_y;
    logic       path_clear;
    logic [9:0] x;
    logic [8:0] y;
    logic [1:0] direction;
    logic [1:0] next_dir;
    logic       moving;
    logic       turning;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] m_lfsr;
    logic [1:0]  exp_d;
    int          ex, ey;

    ghost_mover #(
        .X_W(10), .Y_W(9), .START_X(45), .START_Y(45), .START_DIR(2'b01),
        .STEP_PERIOD(4), .CHECK_LAT(2), .MAX_RETRY(4), .X_MAX(639),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .mode       (mode),
        .target_x   (target_x),
        .target_y   (target_y),
        .path_clear (path_clear),
        .x          (x),
        .y          (y),
        .direction  (direction),
        .next_dir   (next_dir),
        .moving     (moving),
        .turning    (turning)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR for x^16+x^14+x^13+x^11+1, running every cycle
    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= 16'hACE1;
        else      m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fr_exp(input logic [15:0] l, input logic [1:0] d);
        logic [1:0] c;
        logic [1:0] rev;
        c   = l[1:0];
        rev = {d[1], ~d[0]};
        return (c == rev) ? (c ^ 2'b01) : c;
    endfunction

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and plain stepping down
        rst = 1'b0; enable = 1'b1; mode = MODE_RANDOM;
        target_x = '0; target_y = '0; path_clear = 1'b1;
        cyc(3);
        check("rst_x", x, 45);
        check("rst_y", y, 45);
        check("rst_dir", direction, 1);
        check("rst_moving", moving, 0);
        check("rst_turning", turning, 0);
        rst = 1'b1;
        cyc(3);
        check("pre_tick_y", y, 45);
        check("pre_tick_moving", moving, 0);
        cyc(1);
        check("tick1_y", y, 46);
        check("tick1_moving", moving, 1);
        cyc(1);
        check("moving_pulse_end", moving, 0);
        cyc(3);
        check("tick2_y", y, 47);

        // Blocked turn in random mode
        path_clear = 1'b0;
        cyc(3);
        exp_d = m_lfsr[1:0];
        check("rand_next_dir", next_dir, exp_d);
        check("pre_block_turning", turning, 0);
        cyc(1);
        check("block_dir", direction, exp_d);
        check("block_turning", turning, 1);
        check("block_no_step_y", y, 47);
        path_clear = 1'b1;
        cyc(1);
        check("check_wait_turning", turning, 1);
        cyc(1);
        check("check_done_turning", turning, 0);
        ex = 45; ey = 47;
        case (exp_d)
            2'b00:   ey = 46;
            2'b01:   ey = 48;
            2'b10:   ex = 44;
            default: ex = 46;
        endcase
        cyc(2);
        check("new_head_x", x, ex);
        check("new_head_y", y, ey);
        check("new_head_moving", moving, 1);

        // Chase selection and forced reversal
        rst = 1'b0; mode = MODE_CHASE; path_clear = 1'b0;
        target_x = 10'd100; target_y = 9'd50; #1;
        check("chase_right", next_dir, 3);
        target_x = 10'd50; target_y = 9'd10; #1;
        check("chase_up", next_dir, 0);
        target_x = 10'd45; target_y = 9'd45; #1;
        check("chase_same", next_dir, 1);
        target_x = 10'd30; target_y = 9'd50; #1;
        check("chase_left", next_dir, 2);
        target_x = 10'd100; target_y = 9'd50;
        cyc(2);
        rst = 1'b1;
        cyc(4);
        check("chase_turn_dir", direction, 3);
        check("chase_turn_turning", turning, 1);
        path_clear = 1'b1;
        cyc(4);
        check("chase_step_x", x, 46);
        check("chase_step_moving", moving, 1);
        check("chase_step_turning", turning, 0);
        path_clear = 1'b0;
        cyc(4);
        check("rev_entry_turning", turning, 1);
        check("rev_entry_dir", direction, 3);
        cyc(7);
        check("rev_last_try_turning", turning, 1);
        cyc(1);
        check("rev_dir", direction, 2);
        check("rev_turning", turning, 0);
        check("rev_retry_cleared", next_dir, 3);
        check("rev_x", x, 46);

        // Left wrap, frightened entry, hold, right wrap
        rst = 1'b0; mode = MODE_CHASE; path_clear = 1'b0;
        target_x = 10'd0; target_y = 9'd45;
        cyc(2);
        rst = 1'b1;
        cyc(4);
        check("wrap_turn_dir", direction, 2);
        path_clear = 1'b1;
        cyc(180);
        check("reach_zero_x", x, 0);
        cyc(4);
        check("wrap_left_x", x, 639);
        mode = MODE_FRIGHT;
        cyc(1);
        check("fright_rev_dir", direction, 3);
        check("fright_rev_x", x, 639);
        mode = MODE_HOLD;
        cyc(11);
        check("hold_x", x, 639);
        check("hold_y", y, 45);
        check("hold_dir", direction, 3);
        cyc(3);
        mode = MODE_FRIGHT;
        cyc(1);
        check("fright_tick_dir", direction, 2);
        check("fright_tick_x", x, 639);
        check("fright_tick_moving", moving, 0);
        mode = MODE_HOLD;
        cyc(1);
        mode = MODE_FRIGHT;
        cyc(1);
        check("fright_again_dir", direction, 3);
        cyc(2);
        check("wrap_right_x", x, 0);
        check("wrap_right_moving", moving, 1);

        // Freeze: tick counter holds, LFSR keeps running
        cyc(1);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check("fright_next_dir", next_dir, fr_exp(m_lfsr, 2'b11));
        end
        check("freeze_x", x, 0);
        check("freeze_moving", moving, 0);
        enable = 1'b1;
        cyc(2);
        check("resume_pre_x", x, 0);
        cyc(1);
        check("resume_x", x, 1);
        check("resume_moving", moving, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
